mii_rx_nibble_reader: RTL and testbench

Read-side consumer of the emaclite MII receive async FIFO. Runs in the bus/read clock domain and pops 6-bit entries {rx_er, rx_dv, nibble[3:0]}. Strips preamble/SFD, assembles nibbles LSB-first into bytes and streams them to the receive buffer writer over a valid/ready byte interface. Marks the last byte of each frame and flags error conditions.

---
 rtl/mii_rx_pkg.sv | 42 ++++
 rtl/mii_rx_nibble_reader_out_queue.sv | 61 ++++++
 rtl/mii_rx_nibble_reader.sv | 191 +++++++++++++++++++
 tb/tb_mii_rx_nibble_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive nibble reader.
// Holds the receive state encoding, FIFO entry field positions, preamble/SFD
// nibble values and the CRC-32 helpers used when MII_RX_CRC_CHECK_EN is defined.
package mii_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DLO,
    DHI,
    DROP
  } state_t;

  localparam int unsigned NIB_LSB = 0;
  localparam int unsigned DV_BIT  = 4;
  localparam int unsigned ER_BIT  = 5;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mii_rx_nibble_reader_out_queue.sv
// Two-entry {err, last, data} FIFO feeding the byte stream interface.
// Ports: clk/rst_n (async active-low), push + in_* write side,
// pop + out_* read side (head entry), count = occupancy (0..2).
// Simultaneous push and pop are both honoured; the reader never pushes when full.
module mii_rx_out_queue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_err,
  input  logic       pop,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_err,
  output logic [1:0] count
);

  logic [9:0] mem_q [2];
  logic [9:0] mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_err, in_last, in_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign {out_err, out_last, out_data} = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/mii_rx_nibble_reader.sv
// MII receive nibble reader: pops {rx_er, rx_dv, nibble} entries from the
// receive async FIFO, strips preamble/SFD, assembles bytes LSB nibble first
// and streams them out with last/err markers over a valid/ready interface.
// Ports: Clk, Rst_n (async active-low); Fifo_rd_en/Fifo_dout/Fifo_rd_ack/
// Fifo_empty (FIFO read side); M_data/M_last/M_err/M_valid/M_ready (byte
// stream); Frame_len (latched byte count), Frame_done (last byte accepted).
// Optional: define MII_RX_CRC_CHECK_EN to add FCS residue checking to M_err.
module mii_rx_nibble_reader
  import mii_rx_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH      = 6,
  parameter int unsigned C_MAX_FRAME_BYTES = 1522,
  parameter int unsigned C_LEN_WIDTH       = 11
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  output logic                    Fifo_rd_en,
  input  logic [C_DATA_WIDTH-1:0] Fifo_dout,
  input  logic                    Fifo_rd_ack,
  input  logic                    Fifo_empty,
  output logic [7:0]              M_data,
  output logic                    M_last,
  output logic                    M_err,
  output logic                    M_valid,
  input  logic                    M_ready,
  output logic [C_LEN_WIDTH-1:0]  Frame_len,
  output logic                    Frame_done
);

  state_t                 state_q, state_d;
  logic [3:0]             low_q, low_d;
  logic [7:0]             hold_q, hold_d;
  logic                   hold_vld_q, hold_vld_d;
  logic                   sticky_q, sticky_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic [C_LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                   rd_inflight_q;
`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0]            crc_q, crc_d;
`endif

  logic                   dv, er;
  logic [3:0]             nib;
  state_t                 cur;
  logic [7:0]             byte_now;
  logic [C_LEN_WIDTH-1:0] len_inc;
  logic                   eof, eof_err;
  logic                   push, push_last, push_err;
  logic [7:0]             push_data;
  logic                   pop;
  logic [1:0]             out_cnt;

  assign dv  = Fifo_dout[DV_BIT];
  assign er  = Fifo_dout[ER_BIT];
  assign nib = Fifo_dout[NIB_LSB +: 4];

  // In-flight pop is counted against queue space: each entry yields at most one byte.
  assign Fifo_rd_en = !Fifo_empty && (({1'b0, out_cnt} + {2'b00, rd_inflight_q}) < 3'd2);

  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    sticky_d    = sticky_q;
    len_d       = len_q;
    frame_len_d = frame_len_q;
`ifdef MII_RX_CRC_CHECK_EN
    crc_d       = crc_q;
`endif
    push      = 1'b0;
    push_data = hold_q;
    push_last = 1'b0;
    push_err  = 1'b0;
    eof       = 1'b0;
    eof_err   = sticky_q;
    byte_now  = {nib, low_q};
    len_inc   = (len_q == '1) ? len_q : len_q + {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};
    // IDLE hands a dv=1 entry straight to the preamble logic in the same cycle.
    cur       = (state_q == IDLE && dv) ? PRE : state_q;

    if (Fifo_rd_ack) begin
      case (cur)
        PRE: begin
          if (!dv)                       state_d = IDLE;
          else if (er)                   state_d = DROP;
          else if (nib == PREAMBLE_NIB)  state_d = PRE;
          else if (nib == SFD_NIB)       state_d = DLO;
          else                           state_d = DROP;
        end
        DLO: begin
          if (dv) begin
            low_d    = nib;
            sticky_d = sticky_q | er;
            state_d  = DHI;
          end else begin
            eof     = 1'b1;
            eof_err = sticky_q | er;
          end
        end
        DHI: begin
          if (dv) begin
            if (hold_vld_q) begin
              push = 1'b1;
            end
            hold_d     = byte_now;
            hold_vld_d = 1'b1;
            len_d      = len_inc;
            sticky_d   = sticky_q | er | (32'(len_inc) > C_MAX_FRAME_BYTES);
`ifdef MII_RX_CRC_CHECK_EN
            crc_d      = crc32_byte(crc_q, byte_now);
`endif
            state_d    = DLO;
          end else begin
            eof     = 1'b1;
            eof_err = 1'b1;
          end
        end
        DROP: begin
          if (!dv) state_d = IDLE;
        end
        default: ;
      endcase

      if (eof) begin
`ifdef MII_RX_CRC_CHECK_EN
        // Register is reflected; compare its bit-reversal against the residue.
        eof_err = eof_err | (bitrev32(crc_q) != CRC_RESIDUE);
        crc_d   = '1;
`endif
        push        = hold_vld_q;
        push_last   = 1'b1;
        push_err    = eof_err;
        hold_vld_d  = 1'b0;
        sticky_d    = 1'b0;
        len_d       = '0;
        frame_len_d = len_q;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      low_q         <= '0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      sticky_q      <= 1'b0;
      len_q         <= '0;
      frame_len_q   <= '0;
      rd_inflight_q <= 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
      crc_q         <= '1;
`endif
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      sticky_q      <= sticky_d;
      len_q         <= len_d;
      frame_len_q   <= frame_len_d;
      rd_inflight_q <= Fifo_rd_en;
`ifdef MII_RX_CRC_CHECK_EN
      crc_q         <= crc_d;
`endif
    end
  end

  assign M_valid = (out_cnt != 2'd0);
  assign pop     = M_valid && M_ready;

  mii_rx_out_queue u_out_queue (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .push     (push),
    .in_data  (push_data),
    .in_last  (push_last),
    .in_err   (push_err),
    .pop      (pop),
    .out_data (M_data),
    .out_last (M_last),
    .out_err  (M_err),
    .count    (out_cnt)
  );

  assign Frame_len  = frame_len_q;
  assign Frame_done = pop && M_last;

endmodule

// File: tb/tb_mii_rx_nibble_reader.sv
module tb_mii_rx_nibble_reader;

  localparam int unsigned LW = 11;
`ifdef MII_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Fifo_rd_en;
  logic [5:0]    Fifo_dout;
  logic          Fifo_rd_ack;
  logic          Fifo_empty;
  logic [7:0]    M_data;
  logic          M_last;
  logic          M_err;
  logic          M_valid;
  logic          M_ready;
  logic [LW-1:0] Frame_len;
  logic          Frame_done;

  logic [5:0] fifo_q [$];
  logic [9:0] exp_q  [$];
  logic [7:0] frame_b [$];
  int checks = 0;
  int errors = 0;
  int accepted = 0;

  always #5 Clk = ~Clk;

  mii_rx_nibble_reader #(
    .C_DATA_WIDTH      (6),
    .C_MAX_FRAME_BYTES (1522),
    .C_LEN_WIDTH       (LW)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Fifo_rd_en  (Fifo_rd_en),
    .Fifo_dout   (Fifo_dout),
    .Fifo_rd_ack (Fifo_rd_ack),
    .Fifo_empty  (Fifo_empty),
    .M_data      (M_data),
    .M_last      (M_last),
    .M_err       (M_err),
    .M_valid     (M_valid),
    .M_ready     (M_ready),
    .Frame_len   (Frame_len),
    .Frame_done  (Frame_done)
  );

  // FIFO read-side model: a pop accepted at an edge returns data with ack in the next cycle.
  always @(posedge Clk) begin : fifo_model
    bit pop;
    pop = Fifo_rd_en && !Fifo_empty;
    #1;
    Fifo_rd_ack = 1'b0;
    if (pop && fifo_q.size() > 0) begin
      Fifo_dout   = fifo_q.pop_front();
      Fifo_rd_ack = 1'b1;
    end
    Fifo_empty = (fifo_q.size() == 0);
  end

  // Scoreboard: compare each accepted byte against the expected queue.
  always @(negedge Clk) begin : monitor
    logic [9:0] e;
    if (Rst_n && M_valid && M_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got data=%h last=%b err=%b, required none", M_data, M_last, M_err);
      end else begin
        e = exp_q.pop_front();
        if ({M_err, M_last, M_data} !== e) begin
          errors++;
          $display("FAIL byte got err=%b last=%b data=%h, required err=%b last=%b data=%h",
                   M_err, M_last, M_data, e[9], e[8], e[7:0]);
        end
        checks++;
        if (Frame_done !== e[8]) begin
          errors++;
          $display("FAIL frame_done got %b, required %b", Frame_done, e[8]);
        end
      end
      accepted++;
    end
  end

  task automatic push_entry(input bit er, input bit dv, input logic [3:0] nib);
    fifo_q.push_back({er, dv, nib});
  endtask

  // Queue a frame from frame_b; expected last-byte err covers CRC when enabled.
  task automatic send_frame(input int npre, input bit err_exp, input bit fcs_ok);
    bit e;
    e = err_exp | (CRC_ON && !fcs_ok);
    for (int i = 0; i < npre; i++) push_entry(0, 1, 4'h5);
    push_entry(0, 1, 4'hD);
    for (int i = 0; i < frame_b.size(); i++) begin
      push_entry(0, 1, frame_b[i][3:0]);
      push_entry(0, 1, frame_b[i][7:4]);
      if (i == frame_b.size() - 1) exp_q.push_back({e, 1'b1, frame_b[i]});
      else                         exp_q.push_back({1'b0, 1'b0, frame_b[i]});
    end
    push_entry(0, 0, 4'h0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || M_valid) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    repeat (4) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0 || M_valid) begin
      errors++;
      $display("FAIL %s_drain got %0d bytes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_len(input string name, input logic [LW-1:0] want);
    checks++;
    if (Frame_len !== want) begin
      errors++;
      $display("FAIL %s_frame_len got %0d, required %0d", name, Frame_len, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({M_valid, M_data, M_last, M_err, Frame_done} !== 12'h0 || Frame_len !== '0) begin
      errors++;
      $display("FAIL %s got valid=%b data=%h last=%b err=%b done=%b len=%0d, required all 0",
               name, M_valid, M_data, M_last, M_err, Frame_done, Frame_len);
    end
  endtask

  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    bit b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        b = frame_b[i][k] ^ c[0];
        c = c >> 1;
        if (b) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic test_reset();
    Rst_n = 1'b0; M_ready = 1'b0; Fifo_rd_ack = 1'b0; Fifo_empty = 1'b1; Fifo_dout = '0;
    repeat (3) @(negedge Clk);
    check_outputs_zero("reset");
    checks++;
    if (Fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en got %b, required 0", Fifo_rd_en);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    M_ready = 1'b1;
    frame_b = '{8'h12, 8'h34};
    send_frame(15, 0, 0);
    wait_drain("basic", 200);
    check_len("basic", 2);
  endtask

  task automatic test_backpressure();
    M_ready = 1'b0;
    frame_b = '{8'h12, 8'h34};
    send_frame(15, 0, 0);
    frame_b = '{8'h56, 8'h78};
    send_frame(15, 0, 0);
    repeat (60) @(negedge Clk);
    checks++;
    if (Fifo_rd_en !== 1'b0 || Fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL bp_throttle got rd_en=%b empty=%b, required rd_en=0 empty=0", Fifo_rd_en, Fifo_empty);
    end
    checks++;
    if (M_valid !== 1'b1 || M_data !== 8'h12 || M_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got valid=%b data=%h last=%b, required valid=1 data=12 last=0", M_valid, M_data, M_last);
    end
    repeat (20) @(negedge Clk);
    checks++;
    if (M_data !== 8'h12 || Fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_stable got data=%h rd_en=%b, required data=12 rd_en=0", M_data, Fifo_rd_en);
    end
    M_ready = 1'b1;
    wait_drain("backpressure", 300);
    check_len("backpressure", 2);
  endtask

  task automatic test_odd_nibble();
    for (int i = 0; i < 15; i++) push_entry(0, 1, 4'h5);
    push_entry(0, 1, 4'hD);
    push_entry(0, 1, 4'h2); push_entry(0, 1, 4'h1); push_entry(0, 1, 4'h4);
    push_entry(0, 0, 4'h0);
    exp_q.push_back({1'b1, 1'b1, 8'h12});
    wait_drain("odd", 200);
    check_len("odd", 1);
  endtask

  task automatic test_bad_preamble();
    push_entry(0, 1, 4'h5); push_entry(0, 1, 4'h5); push_entry(0, 1, 4'h7);
    push_entry(0, 1, 4'h5); push_entry(0, 1, 4'hD);
    push_entry(0, 1, 4'h1); push_entry(0, 1, 4'h2);
    push_entry(0, 0, 4'h0);
    frame_b = '{8'hA5, 8'h3C, 8'hFF};
    send_frame(7, 0, 0);
    wait_drain("badpre", 200);
    check_len("badpre", 3);
  endtask

  task automatic test_reset_midframe();
    int base, n;
    M_ready = 1'b1;
    base = accepted;
    frame_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(7, 0, 0);
    n = 0;
    while (accepted < base + 2 && n < 200) begin
      @(posedge Clk); #2;
      n++;
    end
    checks++;
    if (accepted < base + 2) begin
      errors++;
      $display("FAIL midreset_wait got %0d bytes, required 2", accepted - base);
    end
    Rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    frame_b = '{8'hC1, 8'hC2, 8'hC3};
    send_frame(7, 0, 0);
    wait_drain("after_reset", 200);
    check_len("after_reset", 3);
  endtask

  task automatic test_max_len();
    frame_b.delete();
    for (int i = 0; i < 1522; i++) frame_b.push_back(8'(i * 3));
    send_frame(7, 0, 0);
    wait_drain("len1522", 5000);
    check_len("len1522", 1522);
    frame_b.push_back(8'h99);
    send_frame(7, 1, 0);
    wait_drain("len1523", 5000);
    check_len("len1523", 1523);
  endtask

`ifdef MII_RX_CRC_CHECK_EN
  task automatic test_crc();
    logic [31:0] fcs;
    frame_b.delete();
    for (int i = 0; i < 60; i++) frame_b.push_back(8'(i * 7 + 3));
    fcs = ref_crc(60);
    for (int k = 0; k < 4; k++) frame_b.push_back(fcs[8*k +: 8]);
    send_frame(7, 0, 1);
    wait_drain("crc_good", 400);
    frame_b[10] = frame_b[10] ^ 8'h04;
    send_frame(7, 1, 1);
    wait_drain("crc_bad", 400);
    check_len("crc", 64);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_odd_nibble();
    test_bad_preamble();
    test_reset_midframe();
    test_max_len();
`ifdef MII_RX_CRC_CHECK_EN
    test_crc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
